i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- Synthesizable, parametrised I2C target (slave) that succeeds the testbench-only responder.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a masked 7-bit address and serves a DEPTH-entry register file with an auto-incrementing pointer; optional clock stretching after write ACKs.
- Sits on the I2C bus opposite the i2cmb master; a host-side port allows inspection and preload of the register file.

Parameters:
- DATA_WIDTH, 8, byte width on the bus and register width; only 8 is legal.
- TARGET_ADDR, 7'h22, 7-bit target address.
- ADDR_MASK, 7'h7F, address bits compared; 0 bits are don't-care.
- DEPTH, 16, register-file entries; power of two, 2..256. Pointer width PW = clog2(DEPTH).
- STRETCH_CYCLES, 0, clk cycles SCL is held low after each write-data ACK; 0 disables stretching.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- scl_i  in  1  bus SCL (resolved).
- sda_i  in  1  bus SDA (resolved).
- scl_oe  out  1  1 = pull SCL low.
- sda_oe  out  1  1 = pull SDA low; open-drain, never drives high.
- host_we  in  1  host write strobe.
- host_addr  in  PW  host register index.
- host_wdata  in  DATA_WIDTH  host write data.
- host_rdata  out  DATA_WIDTH  combinational read of mem[host_addr].
- start_det  out  1  1-cycle pulse on START or repeated START.
- stop_det  out  1  1-cycle pulse on STOP.
- xfer_done  out  1  1-cycle pulse at STOP or repeated START ending an addressed transfer.
- last_rw  out  1  R/W bit of the last matched address byte.
- byte_cnt  out  8  data bytes transferred in the current/last transfer; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; scl_oe=sda_oe=0; all pulses 0; last_rw=0; byte_cnt=0; ptr=0; mem cleared to 0.
- SCL/SDA pass through 2-flop synchronisers; edges are detected on the synchronised values.
  - Sampling occurs on the cycle a synced SCL rise is detected.
  - SDA drive changes on the cycle a synced SCL fall is detected, i.e. 3 clk after the pin edge.
  - Bus requirement: SCL low and high each ≥ 6 clk.
- START: synced SDA falls while synced SCL=1. STOP: synced SDA rises while synced SCL=1. Both are detected in every state and take priority over bit handling.
  - START/repeated START: go to ADDR, clear the bit counter, release sda_oe.
  - STOP: go to IDLE, release sda_oe and scl_oe.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - If (addr ^ TARGET_ADDR) & ADDR_MASK == 0, go to ADDR_ACK; latch last_rw; byte_cnt=0.
    - Otherwise go to IGNORE (no ACK; wait for START/STOP).
  - ADDR_ACK: drive sda_oe=1 for the 9th SCL low/high; on 9th SCL fall go to RD_DATA if R/W=1, else PTR.
  - PTR: shift 8 bits; ptr ← byte[PW-1:0]; ACK via PTR_ACK; then WR_DATA.
  - WR_DATA: shift 8 bits; mem[ptr] ← byte; ptr ← ptr+1 mod DEPTH; byte_cnt++; ACK via WR_ACK.
    - If STRETCH_CYCLES>0, after the ACK clock's SCL fall hold scl_oe=1 for STRETCH_CYCLES clk, then release.
    - Then WR_DATA again.
  - RD_DATA: on entry (SCL low) load shift register from mem[ptr]; drive sda_oe = ~bit, MSB first, updating on each SCL fall; after 8th bit release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on 9th SCL rise.
    - ACK(0): ptr++ mod DEPTH; byte_cnt++; RD_DATA.
    - NACK(1): byte_cnt++; ptr++; go to IGNORE (wait for STOP/Sr).
- Repeated START after PTR_ACK with R/W=1 reads from the newly set ptr (pointer persists across transfers until reset).
- Host write and I2C write to the same index in the same cycle: I2C wins.
- xfer_done fires only if the terminated transfer had a matching address.
- ptr wraps DEPTH-1 → 0 in both directions of use.

Test Plan:
- Write 0x44, ptr=0x03, data 0xA5,0x5A, STOP → ACKs on all 4 bytes; mem[3]=0xA5, mem[4]=0x5A; byte_cnt=2; last_rw=0; xfer_done one pulse.
- Write ptr=0x03, Sr, read 0x45, two bytes (ACK then NACK), STOP → bus returns 0xA5,0x5A; ptr=5; byte_cnt=2; start_det pulsed twice.
- Address 0x50 write → 9th bit SDA high (NACK); no mem change; no xfer_done; stop_det pulses.
- DEPTH=16, ptr=0x0F, write 0x11,0x22,0x33 → mem[15]=0x11, mem[0]=0x22, mem[1]=0x33.
- STRETCH_CYCLES=20, one write-data byte → scl_oe high exactly 20 clk after the ACK clock's SCL fall.
- Assert rst mid read-byte (after 4 bits) → sda_oe=scl_oe=0 immediately; state IDLE; mem cleared; next START addressed normally.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with masked 7-bit address match and an auto-incrementing
// register file; optional SCL stretching after write-data ACKs.
module i2c_target_regfile #(
  parameter int             DATA_WIDTH     = 8,
  parameter logic [6:0]     TARGET_ADDR    = 7'h22,
  parameter logic [6:0]     ADDR_MASK      = 7'h7F,
  parameter int             DEPTH          = 16,
  parameter int             STRETCH_CYCLES = 0,
  localparam int            PW             = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe,
  output logic                  sda_oe,
  input  logic                  host_we,
  input  logic [PW-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  xfer_done,
  output logic                  last_rw,
  output logic [7:0]            byte_cnt
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  localparam logic [15:0] STR = 16'(STRETCH_CYCLES);

  logic scl_m_q, scl_s_q, scl_p_q;
  logic sda_m_q, sda_s_q, sda_p_q;

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [PW-1:0]         ptr_q;
  logic                  sda_oe_q;
  logic                  scl_oe_q;
  logic [15:0]           str_q;
  logic                  last_rw_q;
  logic [7:0]            byte_cnt_q;
  logic                  matched_q;
  logic                  start_q;
  logic                  stop_q;
  logic                  xfer_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic scl_rise, scl_fall;
  logic start_c, stop_c;
  logic wr_en;
  logic addr_hit;
  logic [7:0] cnt_inc;

  // Synchronisers idle high so reset never looks like a bus condition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_m_q <= scl_i;
      scl_s_q <= scl_m_q;
      scl_p_q <= scl_s_q;
      sda_m_q <= sda_i;
      sda_s_q <= sda_m_q;
      sda_p_q <= sda_s_q;
    end
  end

  always_comb begin
    scl_rise = scl_s_q & ~scl_p_q;
    scl_fall = ~scl_s_q & scl_p_q;
    start_c  = scl_s_q & sda_p_q & ~sda_s_q;
    stop_c   = scl_s_q & ~sda_p_q & sda_s_q;
    addr_hit = ((sh_q[DATA_WIDTH-1:1] ^ TARGET_ADDR) & ADDR_MASK) == 7'd0;
    cnt_inc  = (byte_cnt_q == 8'hFF) ? byte_cnt_q : byte_cnt_q + 8'd1;
    wr_en    = (state_q == WR_DATA) && scl_fall && (cnt_q == 4'd8)
               && !start_c && !stop_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      str_q      <= '0;
      last_rw_q  <= 1'b0;
      byte_cnt_q <= '0;
      matched_q  <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      xfer_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      xfer_q  <= 1'b0;
      if (str_q != 16'd0) begin
        str_q <= str_q - 16'd1;
        if (str_q == 16'd1) scl_oe_q <= 1'b0;
      end
      if (start_c) begin
        start_q   <= 1'b1;
        xfer_q    <= matched_q;
        matched_q <= 1'b0;
        state_q   <= ADDR;
        cnt_q     <= '0;
        sda_oe_q  <= 1'b0;
      end else if (stop_c) begin
        stop_q    <= 1'b1;
        xfer_q    <= matched_q;
        matched_q <= 1'b0;
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        scl_oe_q  <= 1'b0;
        str_q     <= '0;
      end else begin
        unique case (state_q)
          ADDR: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sh_q  <= {sh_q[DATA_WIDTH-2:0], sda_s_q};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q <= '0;
              if (addr_hit) begin
                state_q    <= ADDR_ACK;
                sda_oe_q   <= 1'b1;
                last_rw_q  <= sh_q[0];
                byte_cnt_q <= '0;
                matched_q  <= 1'b1;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt_q <= '0;
              if (last_rw_q) begin
                state_q  <= RD_DATA;
                sh_q     <= mem_q[ptr_q];
                sda_oe_q <= ~mem_q[ptr_q][DATA_WIDTH-1];
              end else begin
                state_q  <= PTR;
                sda_oe_q <= 1'b0;
              end
            end
          end
          PTR: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sh_q  <= {sh_q[DATA_WIDTH-2:0], sda_s_q};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q    <= '0;
              ptr_q    <= sh_q[PW-1:0];
              state_q  <= PTR_ACK;
              sda_oe_q <= 1'b1;
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (scl_rise && cnt_q < 4'd8) begin
              sh_q  <= {sh_q[DATA_WIDTH-2:0], sda_s_q};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              cnt_q      <= '0;
              ptr_q      <= ptr_q + 1'b1;
              byte_cnt_q <= cnt_inc;
              state_q    <= WR_ACK;
              sda_oe_q   <= 1'b1;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
              if (STRETCH_CYCLES > 0) begin
                scl_oe_q <= 1'b1;
                str_q    <= STR;
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= RD_ACK;
              end else begin
                sh_q     <= {sh_q[DATA_WIDTH-2:0], 1'b0};
                sda_oe_q <= ~sh_q[DATA_WIDTH-2];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              byte_cnt_q <= cnt_inc;
              ptr_q      <= ptr_q + 1'b1;
              if (sda_s_q) state_q <= IGNORE;
              else         cnt_q   <= 4'd1;
            end else if (scl_fall && cnt_q == 4'd1) begin
              cnt_q    <= '0;
              state_q  <= RD_DATA;
              sh_q     <= mem_q[ptr_q];
              sda_oe_q <= ~mem_q[ptr_q][DATA_WIDTH-1];
            end
          end
          IDLE, IGNORE: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Bus writes take precedence over a host write to the same entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && ptr_q == PW'(i))
          mem_q[i] <= sh_q;
        else if (host_we && host_addr == PW'(i))
          mem_q[i] <= host_wdata;
      end
    end
  end

  assign host_rdata = mem_q[host_addr];
  assign scl_oe     = scl_oe_q;
  assign sda_oe     = sda_oe_q;
  assign start_det  = start_q;
  assign stop_det   = stop_q;
  assign xfer_done  = xfer_q;
  assign last_rw    = last_rw_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master plus an
// array model of the register file and pointer.
module tb_i2c_target_regfile;

  localparam int         DEPTH = 16;
  localparam int         PW    = 4;
  localparam int         SC    = 20;
  localparam logic [6:0] TA    = 7'h22;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic          scl_oe, sda_oe;
  logic          host_we = 1'b0;
  logic [PW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic [7:0]    host_rdata;
  logic          start_det, stop_det, xfer_done, last_rw;
  logic [7:0]    byte_cnt;

  wire scl_bus = m_scl & ~scl_oe;
  wire sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(
    .DATA_WIDTH(8), .TARGET_ADDR(TA), .ADDR_MASK(7'h7F),
    .DEPTH(DEPTH), .STRETCH_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst),
    .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .start_det(start_det), .stop_det(stop_det),
    .xfer_done(xfer_done), .last_rw(last_rw),
    .byte_cnt(byte_cnt)
  );

  int tests = 0;
  int fails = 0;
  int n_start = 0, n_stop = 0, n_xfer = 0;
  int run = 0, last_run = 0;

  always @(posedge clk) begin
    if (start_det) n_start <= n_start + 1;
    if (stop_det)  n_stop  <= n_stop + 1;
    if (xfer_done) n_xfer  <= n_xfer + 1;
    if (scl_oe) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  logic [7:0] mem_m [DEPTH];
  int         ptr_m;
  logic [7:0] wq [$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int k;
    k = 0;
    m_scl = 1'b1;
    while (scl_bus !== 1'b1 && k < 400) begin
      tick(1);
      k++;
    end
    if (k >= 400) check("scl_release_timeout", scl_bus, 1);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; tick(8);
    m_sda = 1'b0; tick(8);
    m_scl = 1'b0; tick(2);
  endtask

  task automatic rep_start();
    m_sda = 1'b1; tick(6);
    scl_up(); tick(8);
    m_sda = 1'b0; tick(8);
    m_scl = 1'b0; tick(2);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(6);
    scl_up(); tick(8);
    m_sda = 1'b1; tick(10);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(6);
      scl_up(); tick(8);
      m_scl = 1'b0; tick(2);
    end
    m_sda = 1'b1; tick(6);
    scl_up(); tick(4);
    ack = sda_bus; tick(4);
    m_scl = 1'b0; tick(2);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(6);
      scl_up(); tick(4);
      b[i] = sda_bus; tick(4);
      m_scl = 1'b0; tick(2);
    end
    m_sda = nack; tick(6);
    scl_up(); tick(8);
    m_scl = 1'b0; tick(2);
    m_sda = 1'b1;
  endtask

  task automatic host_write(input int idx, input logic [7:0] v);
    host_addr = PW'(idx); host_wdata = v; host_we = 1'b1;
    tick(1);
    host_we = 1'b0;
    mem_m[idx] = v;
  endtask

  task automatic hchk(input int idx);
    host_addr = PW'(idx);
    #1;
    check($sformatf("host_rd[%0d]", idx), host_rdata, mem_m[idx]);
  endtask

  task automatic xact_write(input logic [7:0] p);
    logic ack;
    bus_start();
    wr_byte({TA, 1'b0}, ack); check("w_addr_ack", ack, 0);
    wr_byte(p, ack);          check("w_ptr_ack", ack, 0);
    ptr_m = p % DEPTH;
    foreach (wq[i]) begin
      wr_byte(wq[i], ack); check("w_data_ack", ack, 0);
      mem_m[ptr_m] = wq[i];
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    bus_stop();
  endtask

  task automatic xact_read(input bit set_ptr, input logic [7:0] p,
                           input int n);
    logic ack;
    logic [7:0] b;
    bus_start();
    if (set_ptr) begin
      wr_byte({TA, 1'b0}, ack); check("r_waddr_ack", ack, 0);
      wr_byte(p, ack);          check("r_ptr_ack", ack, 0);
      ptr_m = p % DEPTH;
      rep_start();
    end
    wr_byte({TA, 1'b1}, ack); check("r_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, b);
      check("rd_data", b, mem_m[ptr_m]);
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    bus_stop();
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, p0, x0, n, kind;
    logic ack;
    logic [7:0] p;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    ptr_m = 0;

    tick(3);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_last_rw", last_rw, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    check("rst_pulses", {start_det, stop_det, xfer_done}, 0);
    rst = 1'b1;
    tick(5);
    hchk(0);
    hchk(DEPTH - 1);

    // Write 0xA5,0x5A at pointer 3
    x0 = n_xfer;
    wq = '{8'hA5, 8'h5A};
    xact_write(8'h03);
    hchk(3);
    hchk(4);
    check("w_byte_cnt", byte_cnt, 2);
    check("w_last_rw", last_rw, 0);
    check("w_xfer_done", n_xfer - x0, 1);
    check("stretch_len", last_run, SC);
    check("w_scl_oe_idle", scl_oe, 0);

    // Read back with repeated START, then continue from ptr 5
    host_write(5, 8'h9C);
    s0 = n_start;
    xact_read(1'b1, 8'h03, 2);
    check("r_start_cnt", n_start - s0, 2);
    check("r_byte_cnt", byte_cnt, 2);
    check("r_last_rw", last_rw, 1);
    xact_read(1'b0, 8'h00, 1);

    // Non-matching address
    x0 = n_xfer; p0 = n_stop;
    bus_start();
    wr_byte({7'h50, 1'b0}, ack); check("nm_addr_nack", ack, 1);
    wr_byte(8'h07, ack);         check("nm_byte_nack", ack, 1);
    bus_stop();
    check("nm_xfer_done", n_xfer - x0, 0);
    check("nm_stop_det", n_stop - p0, 1);
    hchk(7);

    // Pointer wrap
    wq = '{8'h11, 8'h22, 8'h33};
    xact_write(8'h0F);
    hchk(15);
    hchk(0);
    hchk(1);

    // Randomised mix
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 4);
      p = 8'($urandom);
      if (kind == 0) begin
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        xact_write(p);
        check("rw_byte_cnt", byte_cnt, n);
      end else if (kind == 1) begin
        xact_read(1'b1, p, n);
        check("rr_byte_cnt", byte_cnt, n);
      end else begin
        host_write($urandom_range(0, DEPTH - 1), 8'($urandom));
      end
    end
    for (int i = 0; i < DEPTH; i++) hchk(i);

    // Reset in the middle of a read byte
    host_write(9, 8'h00);
    bus_start();
    wr_byte({TA, 1'b0}, ack);
    wr_byte(8'h09, ack);
    rep_start();
    wr_byte({TA, 1'b1}, ack); check("mr_addr_ack", ack, 0);
    m_sda = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(6); scl_up(); tick(8);
      m_scl = 1'b0; tick(2);
    end
    tick(4);
    check("mr_sda_oe_before", sda_oe, 1);
    rst = 1'b0;
    #1;
    check("mr_sda_oe_after", sda_oe, 0);
    check("mr_scl_oe_after", scl_oe, 0);
    m_scl = 1'b1; m_sda = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    ptr_m = 0;
    tick(5);
    hchk(3);
    hchk(9);
    rst = 1'b1;
    tick(5);
    wq = '{8'hC3};
    xact_write(8'h02);
    hchk(2);
    xact_read(1'b1, 8'h02, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
